// File: rtl/instruction_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_fetch_stage
//  Purpose  : IF stage of the RV32IM pipeline. Owns the program counter,
//             presents it to an asynchronous-read instruction memory, and
//             captures PC/instruction into the IF/ID register. Handles
//             hazard stalls, EX-stage redirects and halts fetch once the PC
//             leaves the instruction memory.
//  Ports    : clk, reset            - clock, synchronous active-high reset
//             stall                 - hold PC and IF/ID this cycle
//             redirect_valid/_pc    - branch/jump redirect (beats stall)
//             imem_pc / imem_instr  - instruction memory address / data
//             ifid_pc, ifid_pc_plus4, ifid_instr, ifid_valid - IF/ID register
//             fetch_misaligned      - pulse: redirect target not word aligned
//             fetch_halted          - fetch stopped (PC out of range)
//             fetch_count           - delivered instructions, saturating
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc_plus4,
    output logic [31:0] ifid_instr,
    output logic        ifid_valid,
    output logic        fetch_misaligned,
    output logic        fetch_halted,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] c_imem_words = 32'(IMEM_WORDS);
    localparam logic [31:0] c_count_max  = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifid_pc;
    logic [31:0] r_ifid_pc_plus4;
    logic [31:0] r_ifid_instr;
    logic        r_ifid_valid;
    logic        r_misaligned;
    logic [31:0] r_count;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_word;
    logic        w_out_of_range;

    // PC+4 wraps naturally at 2^32.
    assign w_pc_plus4     = r_pc + 32'd4;
    // Word index of the PC, zero-extended so it compares against the depth.
    assign w_pc_word      = {2'b00, r_pc[31:2]};
    assign w_out_of_range = (w_pc_word >= c_imem_words);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= ST_RUN;
            r_pc            <= RESET_PC;
            r_ifid_pc       <= 32'h0;
            r_ifid_pc_plus4 <= 32'h0;
            r_ifid_instr    <= NOP_INSTR;
            r_ifid_valid    <= 1'b0;
            r_misaligned    <= 1'b0;
            r_count         <= 32'h0;
        end else begin
            // Only a redirect can raise the misaligned pulse.
            r_misaligned <= 1'b0;

            if (redirect_valid) begin
                // Low address bits are dropped; the word presented this cycle
                // is squashed and IF/ID PCs keep their last values.
                r_pc         <= {redirect_pc[31:2], 2'b00};
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
                r_misaligned <= (redirect_pc[1:0] != 2'b00);
                r_state      <= ST_RUN;
            end else if (r_state == ST_HALT) begin
                // Frozen until a redirect or reset.
            end else if (w_out_of_range) begin
                // Evaluated ahead of stall so a stalled PC past the end of
                // memory still halts.
                r_state      <= ST_HALT;
                r_ifid_instr <= NOP_INSTR;
                r_ifid_valid <= 1'b0;
            end else if (stall) begin
                // Hold PC and IF/ID.
            end else begin
                r_ifid_instr    <= imem_instr;
                r_ifid_pc       <= r_pc;
                r_ifid_pc_plus4 <= w_pc_plus4;
                r_ifid_valid    <= 1'b1;
                r_pc            <= w_pc_plus4;
                if (r_count != c_count_max) begin
                    r_count <= r_count + 32'd1;
                end
            end
        end
    end

    assign imem_pc          = r_pc;
    assign ifid_pc          = r_ifid_pc;
    assign ifid_pc_plus4    = r_ifid_pc_plus4;
    assign ifid_instr       = r_ifid_instr;
    assign ifid_valid       = r_ifid_valid;
    assign fetch_misaligned = r_misaligned;
    assign fetch_halted     = (r_state == ST_HALT);
    assign fetch_count      = r_count;

endmodule
`default_nettype wire
